riscboy_sram_arbiter: RTL and testbench

Shares the single `async_sram_phy` controller-side port between two bus requesters: port 0 is the processor/system bus and port 1 is the display/DMA fetch. The block arbitrates between the two, sequences read, write and bus-turnaround cycles, and drives the registered `ctrl_*` PHY signals. Read data returns to the port that issued the read, in issue order, after a fixed pipeline delay. It sits between the core's bus fabric and `async_sram_phy`, instantiated with `DQ_SYNC_IN = 1`.

---
 rtl/riscboy_sram_arbiter_pkg.sv | 34 +++
 rtl/riscboy_sram_arbiter_rd_tag_pipe.sv | 66 ++++++
 rtl/riscboy_sram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_riscboy_sram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscboy_sram_arbiter_pkg.sv
// Shared definitions for the RISCBoy SRAM arbiter.
// Holds the PHY sequencing states, the requester port indices and the
// arbitration helper used by the top level.
package riscboy_sram_arbiter_pkg;

   // PHY sequencing states. The state register always names the kind of
   // command currently being driven on the registered ctrl_* outputs.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_WR_HOLD,
      ST_TURN
   } phy_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   // Picks the port to serve this cycle. An urgent display fetch wins
   // outright; a lone requester wins; on contention the port that did not
   // win the previous accept goes next.
   function automatic logic pick_port(input logic v0, input logic v1,
                                      input logic urgent, input logic last);
      if (urgent && v1)
         return PORT_DMA;
      else if (v0 && !v1)
         return PORT_CPU;
      else if (v1 && !v0)
         return PORT_DMA;
      else
         return ~last;
   endfunction

endpackage

// File: rtl/riscboy_sram_arbiter_rd_tag_pipe.sv
// Read tag pipe for the SRAM arbiter.
// Every PHY read cycle pushes a {valid, port} tag. After RD_LAT cycles the
// tag lines up with the PHY read data, which is registered into the response
// outputs of the port that issued the read.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (flushes tags)
//   push, push_port     a read command is on the PHY this cycle, and its port
//   dq_in               PHY read data
//   rspN_valid/rdata    per-port one-cycle response pulse and held read data
module riscboy_sram_arbiter_rd_tag_pipe #(
   parameter int W_DATA = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              push_port,
   input  logic [W_DATA-1:0] dq_in,
   output logic              rsp0_valid,
   output logic [W_DATA-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [W_DATA-1:0] rsp1_rdata
);

   logic [RD_LAT-1:0] tag_valid;
   logic [RD_LAT-1:0] tag_port;
   logic              out_valid;
   logic              out_port;

   assign out_valid = tag_valid[RD_LAT-1];
   assign out_port  = tag_port[RD_LAT-1];

   // Tag shift register; reset drops every read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_port  <= '0;
      end else begin
         tag_valid[0] <= push;
         tag_port[0]  <= push_port;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_port[i]  <= tag_port[i-1];
         end
      end
   end

   // Response register: the tag at the end of the pipe coincides with valid
   // PHY data, which is steered to the issuing port and held until replaced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= out_valid && !out_port;
         rsp1_valid <= out_valid && out_port;
         if (out_valid && !out_port)
            rsp0_rdata <= dq_in;
         if (out_valid && out_port)
            rsp1_rdata <= dq_in;
      end
   end

endmodule

// File: rtl/riscboy_sram_arbiter.sv
// RISCBoy SRAM arbiter: shares one async_sram_phy controller port between
// the processor bus (port 0) and the display/DMA fetch (port 1).
// Arbitrates, sequences read / write / turnaround cycles, drives registered
// PHY command signals and routes read data back to the issuing port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_*                     request channel of port N (valid/ready handshake)
//   req1_urgent                port 1 takes absolute priority
//   rspN_valid, rspN_rdata     read response of port N
//   ctrl_*                     registered PHY command outputs, ctrl_dq_in read data
module riscboy_sram_arbiter
   import riscboy_sram_arbiter_pkg::*;
#(
   parameter int W_ADDR = 18,
   parameter int W_DATA = 16,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic                req0_write,
   input  logic [W_ADDR-1:0]   req0_addr,
   input  logic [W_DATA-1:0]   req0_wdata,
   input  logic [W_DATA/8-1:0] req0_ben,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic                req1_write,
   input  logic [W_ADDR-1:0]   req1_addr,
   input  logic [W_DATA-1:0]   req1_wdata,
   input  logic [W_DATA/8-1:0] req1_ben,
   input  logic                req1_urgent,
   output logic                rsp0_valid,
   output logic [W_DATA-1:0]   rsp0_rdata,
   output logic                rsp1_valid,
   output logic [W_DATA-1:0]   rsp1_rdata,
   output logic [W_ADDR-1:0]   ctrl_addr,
   output logic [W_DATA-1:0]   ctrl_dq_out,
   output logic [W_DATA-1:0]   ctrl_dq_oe,
   output logic                ctrl_ce_n,
   output logic                ctrl_we_n,
   output logic                ctrl_oe_n,
   output logic [W_DATA/8-1:0] ctrl_byte_n,
   input  logic [W_DATA-1:0]   ctrl_dq_in
);

   phy_state_t          state, state_next;
   logic                last_grant;
   logic                rd_port;
   logic                grant;
   logic                any_valid;
   logic                can_accept;
   logic                accept;
   logic                g_write;
   logic [W_ADDR-1:0]   g_addr;
   logic [W_DATA-1:0]   g_wdata;
   logic [W_DATA/8-1:0] g_ben;

   logic [W_ADDR-1:0]   addr_next;
   logic [W_DATA-1:0]   dq_out_next;
   logic [W_DATA-1:0]   dq_oe_next;
   logic                ce_n_next, we_n_next, oe_n_next;
   logic [W_DATA/8-1:0] byte_n_next;

   // Arbitration and handshake. The winner is accepted unless the PHY is
   // mid-write, or it wants to write while reads are still on the bus.
   always_comb begin
      any_valid = req0_valid || req1_valid;
      grant     = pick_port(req0_valid, req1_valid, req1_urgent, last_grant);
      g_write   = grant ? req1_write : req0_write;
      g_addr    = grant ? req1_addr  : req0_addr;
      g_wdata   = grant ? req1_wdata : req0_wdata;
      g_ben     = grant ? req1_ben   : req0_ben;
      case (state)
         ST_WR:   can_accept = 1'b0;
         ST_RD:   can_accept = !g_write;
         default: can_accept = 1'b1;
      endcase
      accept     = any_valid && can_accept;
      req0_ready = accept && (grant == PORT_CPU);
      req1_ready = accept && (grant == PORT_DMA);
   end

   // Next PHY state and the command that goes with it. A write blocked by
   // an ongoing read inserts one TURN cycle so the bus can turn around.
   always_comb begin
      state_next  = ST_IDLE;
      addr_next   = ctrl_addr;
      dq_out_next = ctrl_dq_out;
      dq_oe_next  = '0;
      ce_n_next   = 1'b1;
      we_n_next   = 1'b1;
      oe_n_next   = 1'b1;
      byte_n_next = '1;
      if (accept)
         state_next = g_write ? ST_WR : ST_RD;
      else if (state == ST_WR)
         state_next = ST_WR_HOLD;
      else if (state == ST_RD && any_valid && g_write)
         state_next = ST_TURN;
      case (state_next)
         ST_RD: begin
            ce_n_next   = 1'b0;
            oe_n_next   = 1'b0;
            addr_next   = g_addr;
            byte_n_next = (g_ben == '0) ? '0 : ~g_ben;
         end
         ST_WR: begin
            ce_n_next   = 1'b0;
            we_n_next   = 1'b0;
            dq_oe_next  = '1;
            addr_next   = g_addr;
            dq_out_next = g_wdata;
            byte_n_next = ~g_ben;
         end
         ST_WR_HOLD: begin
            ce_n_next   = 1'b0;
            dq_oe_next  = ctrl_dq_oe;
            byte_n_next = ctrl_byte_n;
         end
         default: begin
         end
      endcase
   end

   // State, arbitration history and the port owning the current read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= PORT_DMA;
         rd_port    <= PORT_CPU;
      end else begin
         state <= state_next;
         if (accept)
            last_grant <= grant;
         if (accept && !g_write)
            rd_port <= grant;
      end
   end

   // Registered PHY command outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_addr   <= '0;
         ctrl_dq_out <= '0;
         ctrl_dq_oe  <= '0;
         ctrl_ce_n   <= 1'b1;
         ctrl_we_n   <= 1'b1;
         ctrl_oe_n   <= 1'b1;
         ctrl_byte_n <= '1;
      end else begin
         ctrl_addr   <= addr_next;
         ctrl_dq_out <= dq_out_next;
         ctrl_dq_oe  <= dq_oe_next;
         ctrl_ce_n   <= ce_n_next;
         ctrl_we_n   <= we_n_next;
         ctrl_oe_n   <= oe_n_next;
         ctrl_byte_n <= byte_n_next;
      end
   end

   riscboy_sram_arbiter_rd_tag_pipe #(
      .W_DATA (W_DATA),
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (state == ST_RD),
      .push_port  (rd_port),
      .dq_in      (ctrl_dq_in),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata)
   );

endmodule

// File: tb/tb_riscboy_sram_arbiter.sv
// Testbench for riscboy_sram_arbiter: an SRAM/PHY behavioural model, a
// table of single transactions, hand-written multi-cycle sequences and a
// response scoreboard keyed on issue order, port, data and arrival cycle.
module tb_riscboy_sram_arbiter;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_ready, req0_write = 1'b0;
   logic [17:0] req0_addr = '0;
   logic [15:0] req0_wdata = '0;
   logic [1:0]  req0_ben = '0;
   logic        req1_valid = 1'b0, req1_ready, req1_write = 1'b0;
   logic [17:0] req1_addr = '0;
   logic [15:0] req1_wdata = '0;
   logic [1:0]  req1_ben = '0;
   logic        req1_urgent = 1'b0;
   logic        rsp0_valid, rsp1_valid;
   logic [15:0] rsp0_rdata, rsp1_rdata;
   logic [17:0] ctrl_addr;
   logic [15:0] ctrl_dq_out, ctrl_dq_oe, ctrl_dq_in;
   logic        ctrl_ce_n, ctrl_we_n, ctrl_oe_n;
   logic [1:0]  ctrl_byte_n;

   int vecCount = 0;
   int miscompares = 0;
   int cyc = 0;

   riscboy_sram_arbiter #(.W_ADDR(18), .W_DATA(16), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ben(req0_ben),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ben(req1_ben),
      .req1_urgent(req1_urgent),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ctrl_addr(ctrl_addr), .ctrl_dq_out(ctrl_dq_out), .ctrl_dq_oe(ctrl_dq_oe),
      .ctrl_ce_n(ctrl_ce_n), .ctrl_we_n(ctrl_we_n), .ctrl_oe_n(ctrl_oe_n),
      .ctrl_byte_n(ctrl_byte_n), .ctrl_dq_in(ctrl_dq_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM contents; unwritten words read back as an address-derived pattern.
   logic [15:0] mem [int unsigned];
   logic [15:0] rdPipe [RD_LAT];

   function automatic logic [15:0] memRead(input logic [17:0] a);
      if (mem.exists(int'(a)))
         return mem[int'(a)];
      return {a[7:0], a[15:8]} ^ 16'h1234;
   endfunction

   assign ctrl_dq_in = rdPipe[RD_LAT-1];

   // PHY + SRAM model: reads return RD_LAT cycles after the oe_n cycle,
   // writes land with byte masking on the we_n cycle.
   always @(posedge clk) begin
      logic [15:0] w;
      if (!ctrl_ce_n && !ctrl_we_n) begin
         w = memRead(ctrl_addr);
         if (!ctrl_byte_n[0]) w[7:0]  = ctrl_dq_out[7:0];
         if (!ctrl_byte_n[1]) w[15:8] = ctrl_dq_out[15:8];
         mem[int'(ctrl_addr)] = w;
      end
      rdPipe[0] <= (!ctrl_ce_n && !ctrl_oe_n) ? memRead(ctrl_addr) : 16'hxxxx;
      for (int i = 1; i < RD_LAT; i++)
         rdPipe[i] <= rdPipe[i-1];
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: reads push expectations on accept; responses pop them.
   typedef struct {
      bit          port;
      logic [15:0] data;
      int          due;
   } sb_t;
   sb_t sb[$];

   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin
               if (sb.size() == 0) begin
                  vecCount++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_rsp: port %0d pulsed, expected no response", p);
               end else begin
                  e = sb.pop_front();
                  checkOutput("rsp_port", p, e.port);
                  checkOutput("rsp_data", (p == 0) ? rsp0_rdata : rsp1_rdata, e.data);
                  checkOutput("rsp_cycle", cyc, e.due);
               end
            end
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            vecCount++;
            miscompares++;
            $display("[TB] FAIL missing_rsp: port %0d no response, expected one at cycle %0d", e.port, e.due);
         end
         if (req0_valid && req0_ready && !req0_write)
            sb.push_back('{1'b0, memRead(req0_addr), cyc + 2 + RD_LAT});
         if (req1_valid && req1_ready && !req1_write)
            sb.push_back('{1'b1, memRead(req1_addr), cyc + 2 + RD_LAT});
      end
   end

   // Presents one request and holds it until accepted; returns one cycle
   // after the accepting edge, when the PHY command is visible.
   task automatic applyStimulus(input bit p, input bit wr, input logic [17:0] a,
                                input logic [15:0] d, input logic [1:0] b);
      bit ok = 0;
      if (!p) begin
         req0_write = wr; req0_addr = a; req0_wdata = d; req0_ben = b; req0_valid = 1'b1;
      end else begin
         req1_write = wr; req1_addr = a; req1_wdata = d; req1_ben = b; req1_valid = 1'b1;
      end
      for (int i = 0; i < 16 && !ok; i++) begin
         @(negedge clk);
         ok = p ? req1_ready : req0_ready;
      end
      if (!ok) begin
         vecCount++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: port %0d not accepted, expected ready", p);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   typedef struct {
      bit          port;
      bit          wr;
      logic [17:0] addr;
      logic [15:0] wdata;
      logic [1:0]  ben;
      logic [1:0]  exp_byte_n;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11, 2'b00};
      vecs[1] = '{1'b1, 1'b1, 18'h3FFFF, 16'hA55A, 2'b10, 2'b01};
      vecs[2] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 2'b00};
      vecs[3] = '{1'b1, 1'b0, 18'h00020, 16'h0000, 2'b01, 2'b10};
      vecs[4] = '{1'b0, 1'b1, 18'h00020, 16'h1234, 2'b11, 2'b00};
      vecs[5] = '{1'b1, 1'b0, 18'h00020, 16'h0000, 2'b11, 2'b00};
      mem[32'h10] = 16'hBEEF;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ce_n", ctrl_ce_n, 1);
      checkOutput("rst_oe_n", ctrl_oe_n, 1);
      checkOutput("rst_we_n", ctrl_we_n, 1);
      checkOutput("rst_dq_oe", ctrl_dq_oe, 0);
      checkOutput("rst_addr", ctrl_addr, 0);
      checkOutput("rst_dq_out", ctrl_dq_out, 0);
      checkOutput("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      checkOutput("rst_rsp_rdata", {rsp0_rdata, rsp1_rdata}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Table of single transactions
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].ben);
         checkOutput("cmd_ce_n", ctrl_ce_n, 0);
         checkOutput("cmd_oe_n", ctrl_oe_n, vecs[v].wr ? 1 : 0);
         checkOutput("cmd_we_n", ctrl_we_n, vecs[v].wr ? 0 : 1);
         checkOutput("cmd_addr", ctrl_addr, vecs[v].addr);
         checkOutput("cmd_byte_n", ctrl_byte_n, vecs[v].exp_byte_n);
         checkOutput("cmd_dq_oe", ctrl_dq_oe, vecs[v].wr ? 16'hFFFF : 16'h0000);
         if (vecs[v].wr) begin
            checkOutput("wr_dq_out", ctrl_dq_out, vecs[v].wdata);
            @(posedge clk); #1;
            checkOutput("hold_we_n", ctrl_we_n, 1);
            checkOutput("hold_addr", ctrl_addr, vecs[v].addr);
            checkOutput("hold_dq_oe", ctrl_dq_oe, 16'hFFFF);
            checkOutput("hold_dq_out", ctrl_dq_out, vecs[v].wdata);
         end
         repeat (6) @(posedge clk);
         #1;
         if (v == 0) checkOutput("rsp0_beef", rsp0_rdata, 16'hBEEF);
         if (v == 1) checkOutput("mem_bytemask", memRead(18'h3FFFF), 16'hA5CB);
         if (v == 2) checkOutput("rsp0_masked", rsp0_rdata, 16'hA5CB);
         if (v == 5) checkOutput("rsp1_written", rsp1_rdata, 16'h1234);
      end

      // Contended back-to-back reads: alternate, then urgent, then resume
      req0_write = 1'b0; req0_addr = 18'h00100; req0_ben = 2'b11; req0_valid = 1'b1;
      req1_write = 1'b0; req1_addr = 18'h00200; req1_ben = 2'b11; req1_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("alt_ready0", req0_ready, (i % 2) == 0);
         checkOutput("alt_ready1", req1_ready, (i % 2) == 1);
         @(posedge clk); #1;
      end
      req1_urgent = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("urg_ready0", req0_ready, 0);
         checkOutput("urg_ready1", req1_ready, 1);
         @(posedge clk); #1;
      end
      req1_urgent = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("resume_ready0", req0_ready, i == 0);
         checkOutput("resume_ready1", req1_ready, i == 1);
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Read immediately followed by a write: RD, TURN, WR, WR_HOLD, then read
      applyStimulus(1'b0, 1'b0, 18'h00030, 16'h0000, 2'b11);
      req0_write = 1'b1; req0_addr = 18'h00031; req0_wdata = 16'hCAFE; req0_ben = 2'b11;
      req0_valid = 1'b1;
      @(negedge clk);
      checkOutput("rd_blocks_wr", req0_ready, 0);
      @(posedge clk); #1;
      checkOutput("turn_strobes", {ctrl_ce_n, ctrl_oe_n, ctrl_we_n}, 3'b111);
      checkOutput("turn_dq_oe", ctrl_dq_oe, 0);
      @(negedge clk);
      checkOutput("turn_accept", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      checkOutput("wr_we_n", ctrl_we_n, 0);
      checkOutput("wr_dq_oe", ctrl_dq_oe, 16'hFFFF);
      checkOutput("wr_data", ctrl_dq_out, 16'hCAFE);
      req1_write = 1'b0; req1_addr = 18'h00040; req1_ben = 2'b11; req1_valid = 1'b1;
      @(negedge clk);
      checkOutput("wr_ready1_low", req1_ready, 0);
      @(posedge clk); #1;
      checkOutput("whold_we_n", ctrl_we_n, 1);
      @(negedge clk);
      checkOutput("whold_ready1", req1_ready, 1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      checkOutput("post_wr_oe_n", ctrl_oe_n, 0);
      checkOutput("post_wr_addr", ctrl_addr, 18'h00040);
      repeat (8) @(posedge clk);
      #1;

      // Reset one cycle after a read is accepted
      applyStimulus(1'b0, 1'b0, 18'h00050, 16'h0000, 2'b11);
      checkOutput("pre_rst_oe_n", ctrl_oe_n, 0);
      rst_n = 1'b0;
      #1;
      sb.delete();
      checkOutput("async_rst_oe_n", ctrl_oe_n, 1);
      checkOutput("async_rst_ce_n", ctrl_ce_n, 1);
      checkOutput("async_rst_addr", ctrl_addr, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("post_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
      req0_write = 1'b0; req0_addr = 18'h00060; req0_ben = 2'b11; req0_valid = 1'b1;
      req1_write = 1'b0; req1_addr = 18'h00070; req1_ben = 2'b11; req1_valid = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_grant0", req0_ready, 1);
      checkOutput("post_rst_grant1", req1_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("post_rst_second", req1_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      if (sb.size() != 0) begin
         vecCount++;
         miscompares++;
         $display("[TB] FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
      $finish;
   end

endmodule
